// File: rtl/rgb_stream_packer.sv
// Packs 24-bit RGB pixels into a 32-bit AXI4-Stream, four pixels to three words.
// Frame start travels on tuser, line end on tlast; pack_err flags misaligned sof/eol.
module rgb_stream_packer #(
    parameter bit BGR_LOW = 1'b1
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    input  logic        valid,
    input  logic        sof,
    input  logic        eol,
    output logic        in_stream_ready,
    output logic [31:0] out_stream_tdata,
    output logic [3:0]  out_stream_tkeep,
    output logic        out_stream_tlast,
    output logic        out_stream_tuser,
    output logic        out_stream_tvalid,
    input  logic        out_stream_tready,
    output logic        pack_err
);

    typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_e;

    phase_e      phase_q, phase_d, ph_eff;
    logic [23:0] residue_q, residue_d;
    logic        user_pend_q, user_pend_d;
    logic        tvalid_q, tvalid_d;
    logic [31:0] tdata_q, tdata_d;
    logic        tlast_q, tlast_d;
    logic        tuser_q, tuser_d;
    logic        pack_err_q, pack_err_d;

    logic [23:0] pixel;
    logic        acc;
    logic        emit;
    logic        word_user;
    logic [31:0] word;

    assign pixel = BGR_LOW ? {r, g, b} : {b, g, r};

    // Ready depends on tready combinationally so a retiring word and a new word share one edge.
    assign in_stream_ready = aresetn & (~tvalid_q | out_stream_tready);
    assign acc             = valid & in_stream_ready;

    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        phase_d     = phase_q;
        residue_d   = residue_q;
        user_pend_d = user_pend_q;
        tvalid_d    = tvalid_q & ~out_stream_tready;
        tdata_d     = tdata_q;
        tlast_d     = tlast_q;
        tuser_d     = tuser_q;
        pack_err_d  = pack_err_q;
        ph_eff      = phase_q;
        emit        = 1'b0;
        word_user   = 1'b0;
        word        = '0;

        if (acc) begin
            // A sof outside PH0 throws away the residue and restarts the group.
            if (sof && phase_q != PH0) begin
                ph_eff     = PH0;
                pack_err_d = 1'b1;
            end

            unique case (ph_eff)
                PH0: begin
                    residue_d   = pixel;
                    user_pend_d = sof;
                    word        = {8'h00, pixel};
                    word_user   = sof;
                    emit        = eol;
                    phase_d     = PH1;
                end
                PH1: begin
                    word        = {pixel[7:0], residue_q};
                    word_user   = user_pend_q;
                    user_pend_d = 1'b0;
                    residue_d   = {8'h00, pixel[23:8]};
                    emit        = 1'b1;
                    phase_d     = PH2;
                end
                PH2: begin
                    word      = {pixel[15:0], residue_q[15:0]};
                    residue_d = {16'h0000, pixel[23:16]};
                    emit      = 1'b1;
                    phase_d   = PH3;
                end
                PH3: begin
                    word    = {pixel, residue_q[7:0]};
                    emit    = 1'b1;
                    phase_d = PH0;
                end
            endcase

            if (emit) begin
                tvalid_d = 1'b1;
                tdata_d  = word;
                tlast_d  = eol;
                tuser_d  = word_user;
            end

            // A line may end in any phase; anything short of PH3 leaves bytes behind.
            if (eol) begin
                phase_d = PH0;
                if (ph_eff != PH3) pack_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            phase_q     <= PH0;
            residue_q   <= '0;
            user_pend_q <= 1'b0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            tlast_q     <= 1'b0;
            tuser_q     <= 1'b0;
            pack_err_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            phase_q     <= phase_d;
            residue_q   <= residue_d;
            user_pend_q <= user_pend_d;
            tvalid_q    <= tvalid_d;
            tdata_q     <= tdata_d;
            tlast_q     <= tlast_d;
            tuser_q     <= tuser_d;
            pack_err_q  <= pack_err_d;
        end
    end

    assign out_stream_tdata  = tdata_q;
    assign out_stream_tkeep  = 4'hF;
    assign out_stream_tlast  = tlast_q;
    assign out_stream_tuser  = tuser_q;
    assign out_stream_tvalid = tvalid_q;
    assign pack_err          = pack_err_q;

endmodule

// File: tb/tb_rgb_stream_packer.sv
// Bench for rgb_stream_packer: a byte-queue reference model feeds a scoreboard
// that a decoupled monitor drains on every accepted output word.
module tb_rgb_stream_packer;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [7:0]  r = '0, g = '0, b = '0;
    logic        valid = 1'b0, sof = 1'b0, eol = 1'b0;
    logic        in_stream_ready;
    logic [31:0] out_stream_tdata;
    logic [3:0]  out_stream_tkeep;
    logic        out_stream_tlast, out_stream_tuser, out_stream_tvalid;
    logic        out_stream_tready = 1'b0;
    logic        pack_err;

    rgb_stream_packer #(.BGR_LOW(1'b1)) dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .r                 (r),
        .g                 (g),
        .b                 (b),
        .valid             (valid),
        .sof               (sof),
        .eol               (eol),
        .in_stream_ready   (in_stream_ready),
        .out_stream_tdata  (out_stream_tdata),
        .out_stream_tkeep  (out_stream_tkeep),
        .out_stream_tlast  (out_stream_tlast),
        .out_stream_tuser  (out_stream_tuser),
        .out_stream_tvalid (out_stream_tvalid),
        .out_stream_tready (out_stream_tready),
        .pack_err          (pack_err)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        user;
    } word_t;

    word_t      exp_q[$];
    logic [7:0] bq[$];
    bit         ufl;
    bit         exp_err;
    int         n_vec;
    int         n_err;
    int         rmode;
    int         cyc;
    int         words_in_line;
    int         last_line_len;
    int         lines_seen;
    int         users_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: a pixel adds three bytes (byte 0 first) to a byte queue; every
    // four bytes make a word; a line end flushes, padding or dropping as needed.
    task automatic model_pixel(input logic [23:0] p, input logic s, input logic e);
        word_t wd;
        bit    emitted = 1'b0;
        if (s) begin
            if (bq.size() != 0) exp_err = 1'b1;
            bq.delete();
            ufl = 1'b1;
        end else if (bq.size() == 0) begin
            ufl = 1'b0;
        end
        for (int i = 0; i < 3; i++) bq.push_back(p[8*i +: 8]);
        if (bq.size() >= 4) begin
            wd.data = {bq[3], bq[2], bq[1], bq[0]};
            wd.last = e;
            wd.user = ufl;
            repeat (4) void'(bq.pop_front());
            exp_q.push_back(wd);
            ufl     = 1'b0;
            emitted = 1'b1;
        end
        if (e) begin
            if (!emitted) begin
                wd.data = {8'h00, bq[2], bq[1], bq[0]};
                wd.last = 1'b1;
                wd.user = ufl;
                exp_q.push_back(wd);
                ufl     = 1'b0;
                exp_err = 1'b1;
            end else if (bq.size() != 0) begin
                exp_err = 1'b1;
            end
            bq.delete();
        end
    endtask

    always @(negedge aclk) begin
        cyc++;
        case (rmode)
            0:       out_stream_tready = 1'b1;
            1:       out_stream_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
            2:       out_stream_tready = 1'($urandom_range(0, 1));
            default: out_stream_tready = 1'b0;
        endcase
    end

    // Monitor: pops the scoreboard on each handshake and checks held words.
    initial begin
        bit    prev_stall = 1'b0;
        word_t prev_w;
        word_t ew;
        forever begin
            @(negedge aclk);
            #3;
            if (!aresetn) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_tvalid", 32'(out_stream_tvalid), 32'd1);
                    check("stall_tdata", out_stream_tdata, prev_w.data);
                    check("stall_flags", {30'd0, out_stream_tlast, out_stream_tuser},
                          {30'd0, prev_w.last, prev_w.user});
                end
                if (out_stream_tvalid && out_stream_tready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_word: got %h, expected no word", out_stream_tdata);
                    end else begin
                        ew = exp_q.pop_front();
                        check("tdata", out_stream_tdata, ew.data);
                        check("tlast", 32'(out_stream_tlast), 32'(ew.last));
                        check("tuser", 32'(out_stream_tuser), 32'(ew.user));
                        check("tkeep", 32'(out_stream_tkeep), 32'hF);
                    end
                    words_in_line++;
                    if (out_stream_tuser) users_seen++;
                    if (out_stream_tlast) begin
                        last_line_len = words_in_line;
                        words_in_line = 0;
                        lines_seen++;
                    end
                end
                prev_stall  = out_stream_tvalid && !out_stream_tready;
                prev_w.data = out_stream_tdata;
                prev_w.last = out_stream_tlast;
                prev_w.user = out_stream_tuser;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge aclk);
            valid = 1'b0;
            sof   = 1'b0;
            eol   = 1'b0;
        end
    endtask

    task automatic send(input logic [23:0] p, input logic s, input logic e, input int gap);
        bit done = 1'b0;
        if (gap > 0) idle(gap);
        @(negedge aclk);
        {r, g, b} = p;
        sof   = s;
        eol   = e;
        valid = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            #2;
            if (in_stream_ready) begin
                @(posedge aclk);
                model_pixel(p, s, e);
                done = 1'b1;
            end else begin
                @(negedge aclk);
            end
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got no acceptance, expected one within 200 cycles");
        end
    endtask

    task automatic drain();
        int t = 0;
        idle(1);
        while (exp_q.size() != 0 && t < 2000) begin
            @(negedge aclk);
            t++;
        end
        idle(3);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d words outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        check("pack_err", 32'(pack_err), 32'(exp_err));
    endtask

    task automatic reset_pulse();
        @(negedge aclk);
        aresetn = 1'b0;
        exp_q.delete();
        bq.delete();
        ufl     = 1'b0;
        exp_err = 1'b0;
        #1;
        check("rst_tvalid", 32'(out_stream_tvalid), 32'd0);
        check("rst_ready", 32'(in_stream_ready), 32'd0);
        check("rst_tdata", out_stream_tdata, 32'd0);
        check("rst_pack_err", 32'(pack_err), 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        words_in_line = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int l0, u0;
        rmode = 0;

        // T1: reset with valid asserted
        valid = 1'b1;
        {r, g, b} = 24'h123456;
        repeat (3) @(negedge aclk);
        #1;
        check("t1_tvalid", 32'(out_stream_tvalid), 32'd0);
        check("t1_ready", 32'(in_stream_ready), 32'd0);
        check("t1_tdata", out_stream_tdata, 32'd0);
        check("t1_tlast_tuser", {30'd0, out_stream_tlast, out_stream_tuser}, 32'd0);
        valid = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        #1;
        check("t1_ready_after", 32'(in_stream_ready), 32'd1);

        // T2: one aligned group
        send(24'h010203, 1'b1, 1'b0, 0);
        send(24'h040506, 1'b0, 1'b0, 0);
        send(24'h070809, 1'b0, 1'b0, 0);
        send(24'h0A0B0C, 1'b0, 1'b1, 0);
        drain();
        check("t2_pack_err", 32'(pack_err), 32'd0);

        // T3: full line under 1,0,0,1 backpressure
        rmode = 1;
        for (int i = 0; i < 960; i++)
            send(24'($urandom), i == 0, i == 959, 0);
        drain();
        check("t3_line_words", 32'(last_line_len), 32'd720);

        // T4: small frame, random gaps and random backpressure
        rmode = 2;
        l0 = lines_seen;
        u0 = users_seen;
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 64; x++)
                send(24'($urandom), (x == 0) && (y == 0), x == 63, $urandom_range(0, 2) == 0 ? 1 : 0);
        drain();
        check("t4_lines", 32'(lines_seen - l0), 32'd4);
        check("t4_tuser_count", 32'(users_seen - u0), 32'd1);
        check("t4_line_words", 32'(last_line_len), 32'd48);

        // T5: misaligned eol in PH1, then a clean group from PH0
        rmode = 0;
        reset_pulse();
        send(24'hAABBCC, 1'b1, 1'b0, 0);
        send(24'h112233, 1'b0, 1'b1, 0);
        drain();
        check("t5_pack_err", 32'(pack_err), 32'd1);
        for (int i = 0; i < 4; i++) send(24'($urandom), 1'b0, i == 3, 0);
        drain();

        // T6: async reset while a word is stalled
        rmode = 3;
        reset_pulse();
        send(24'h102030, 1'b1, 1'b0, 0);
        send(24'h405060, 1'b0, 1'b0, 0);
        idle(2);
        #1;
        check("t6_stalled", 32'(out_stream_tvalid), 32'd1);
        @(negedge aclk);
        aresetn = 1'b0;
        exp_q.delete();
        bq.delete();
        ufl     = 1'b0;
        exp_err = 1'b0;
        #1;
        check("t6_tvalid_now", 32'(out_stream_tvalid), 32'd0);
        rmode = 0;
        @(negedge aclk);
        aresetn = 1'b1;
        for (int i = 0; i < 4; i++) send(24'($urandom), 1'b0, 1'b0, 0);
        drain();

        // Random sof/eol placement including misalignment
        rmode = 2;
        reset_pulse();
        for (int i = 0; i < 400; i++)
            send(24'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 3) == 0 ? 1 : 0);
        drain();
        idle(4);
        #1;
        check("end_tvalid_idle", 32'(out_stream_tvalid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
